// File: rtl/bpsk_symbol_sequencer.sv
// bpsk_symbol_sequencer
// Turns a stream of data bits into sine-ROM read addresses for a BPSK modulator.
// A 1 bit starts the carrier at 0 degrees (address 0). A 0 bit starts it at
// 180 degrees (address SAMPLES/2). Each symbol spans CYCLES_PER_SYM carrier
// periods. The next bit is fetched on the last sample, so consecutive symbols
// abut with no gap.
module bpsk_symbol_sequencer #(
   parameter int SAMPLES        = 30,
   parameter int CYCLES_PER_SYM = 2,
   parameter int ADDR_W         = 5
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              enable,
   input  logic              bit_valid,
   input  logic              bit_data,
   output logic              bit_ready,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              sample_valid,
   output logic              symbol_start,
   output logic              busy,
   output logic              underrun
);

   localparam int CYC_W = (CYCLES_PER_SYM > 1) ? $clog2(CYCLES_PER_SYM) : 1;

   localparam logic [ADDR_W:0]   SAMPLES_X = (ADDR_W+1)'(SAMPLES);
   localparam logic [ADDR_W-1:0] LAST_SAMP = ADDR_W'(SAMPLES - 1);
   localparam logic [ADDR_W-1:0] HALF_ADDR = ADDR_W'(SAMPLES / 2);
   localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(CYCLES_PER_SYM - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_p0, state_d;
   logic [ADDR_W-1:0] rom_addr_p0, rom_addr_d;
   logic [ADDR_W-1:0] samp_cnt_p0, samp_cnt_d;
   logic [CYC_W-1:0]  cyc_cnt_p0, cyc_cnt_d;
   logic              sym_start_p0, sym_start_d;
   logic              underrun_p0, underrun_d;
   logic              last_samp;
   logic              accept;

   // Advance one ROM entry. The sum is formed one bit wider so that the wrap
   // back into 0..SAMPLES-1 works even when SAMPLES equals 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] s;
      s = {1'b0, a} + (ADDR_W+1)'(1);
      if (s >= SAMPLES_X) begin
         s = s - SAMPLES_X;
      end
      return s[ADDR_W-1:0];
   endfunction

   assign last_samp = (state_p0 == RUN) && (samp_cnt_p0 == LAST_SAMP) &&
                      (cyc_cnt_p0 == LAST_CYC);
   assign bit_ready = enable & ((state_p0 == IDLE) | last_samp);
   assign accept    = bit_valid & bit_ready;

   assign rom_addr     = rom_addr_p0;
   assign busy         = (state_p0 == RUN);
   assign sample_valid = (state_p0 == RUN) & enable;
   assign symbol_start = sym_start_p0 & enable;
   assign underrun     = underrun_p0;

   // Next-state and datapath update. With enable low, everything holds.
   always_comb begin
      state_d     = state_p0;
      rom_addr_d  = rom_addr_p0;
      samp_cnt_d  = samp_cnt_p0;
      cyc_cnt_d   = cyc_cnt_p0;
      sym_start_d = sym_start_p0;
      underrun_d  = 1'b0;
      if (enable) begin
         sym_start_d = 1'b0;
         if (accept) begin
            state_d     = RUN;
            rom_addr_d  = bit_data ? '0 : HALF_ADDR;
            samp_cnt_d  = '0;
            cyc_cnt_d   = '0;
            sym_start_d = 1'b1;
         end else if (last_samp) begin
            state_d    = IDLE;
            rom_addr_d = '0;
            underrun_d = 1'b1;
         end else if (state_p0 == RUN) begin
            rom_addr_d = addr_wrap_inc(rom_addr_p0);
            if (samp_cnt_p0 == LAST_SAMP) begin
               samp_cnt_d = '0;
               cyc_cnt_d  = cyc_cnt_p0 + CYC_W'(1);
            end else begin
               samp_cnt_d = samp_cnt_p0 + ADDR_W'(1);
            end
         end
      end
   end

   // State and sample registers. The asynchronous reset aborts any symbol in progress.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_p0     <= IDLE;
         rom_addr_p0  <= '0;
         samp_cnt_p0  <= '0;
         cyc_cnt_p0   <= '0;
         sym_start_p0 <= 1'b0;
         underrun_p0  <= 1'b0;
      end else begin
         state_p0     <= state_d;
         rom_addr_p0  <= rom_addr_d;
         samp_cnt_p0  <= samp_cnt_d;
         cyc_cnt_p0   <= cyc_cnt_d;
         sym_start_p0 <= sym_start_d;
         underrun_p0  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_bpsk_symbol_sequencer.sv
// Directed testbench for bpsk_symbol_sequencer with default parameters
// (30 samples per period, 2 periods per symbol).
module tb_bpsk_symbol_sequencer;

   localparam int ADDR_W = 5;

   logic              Clk;
   logic              Rst_n;
   logic              enable;
   logic              bit_valid;
   logic              bit_data;
   logic              bit_ready;
   logic [ADDR_W-1:0] rom_addr;
   logic              sample_valid;
   logic              symbol_start;
   logic              busy;
   logic              underrun;

   int n_vec;
   int n_err;

   bpsk_symbol_sequencer #(
      .SAMPLES(30),
      .CYCLES_PER_SYM(2),
      .ADDR_W(ADDR_W)
   ) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .enable(enable),
      .bit_valid(bit_valid),
      .bit_data(bit_data),
      .bit_ready(bit_ready),
      .rom_addr(rom_addr),
      .sample_valid(sample_valid),
      .symbol_start(symbol_start),
      .busy(busy),
      .underrun(underrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic              en;
      logic              v;
      logic              d;
      logic [ADDR_W-1:0] addr;
      logic              sv;
      logic              ss;
      logic              bsy;
      logic              und;
      logic              rdy;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string nm, input logic [ADDR_W-1:0] ea, input logic esv,
                        input logic ess, input logic eb, input logic eu, input logic er);
      n_vec++;
      if (rom_addr !== ea || sample_valid !== esv || symbol_start !== ess ||
          busy !== eb || underrun !== eu || bit_ready !== er) begin
         n_err++;
         $display("FAIL %s: addr/sv/ss/busy/und/rdy got %0d/%b/%b/%b/%b/%b want %0d/%b/%b/%b/%b/%b",
                  nm, rom_addr, sample_valid, symbol_start, busy, underrun, bit_ready,
                  ea, esv, ess, eb, eu, er);
      end
   endtask

   // Drive inputs just after a rising edge, check at the falling edge, then step past the next rising edge.
   task automatic step(input string nm, input logic en, input logic v, input logic d,
                       input logic [ADDR_W-1:0] ea, input logic esv, input logic ess,
                       input logic eb, input logic eu, input logic er);
      enable    = en;
      bit_valid = v;
      bit_data  = d;
      @(negedge Clk);
      check(nm, ea, esv, ess, eb, eu, er);
      @(posedge Clk);
      #1;
   endtask

   // Runs one full symbol of 60 samples from start address st with bit_valid low, then checks the underrun cycle.
   task automatic run_symbol(input string nm, input int st);
      for (int i = 0; i < 60; i++) begin
         step($sformatf("%s_s%0d", nm, i), 1'b1, 1'b0, 1'b0, ADDR_W'((st + i) % 30),
              1'b1, (i == 0), 1'b1, 1'b0, (i == 59));
      end
      step({nm, "_underrun"}, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   // Watchdog on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t want under 200000", $time);
      $fatal(1);
   end

   initial begin
      int vcount;
      n_vec = 0;
      n_err = 0;

      //           en    v     d     addr sv    ss    busy  und   rdy
      tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset held low
      Rst_n     = 1'b0;
      enable    = 1'b1;
      bit_valid = 1'b0;
      bit_data  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check($sformatf("in_reset_%0d", i), '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;

      // Idle behaviour, including valid offered while frozen
      for (int i = 0; i < 6; i++) begin
         step($sformatf("tbl_%0d", i), tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].addr,
              tbl[i].sv, tbl[i].ss, tbl[i].bsy, tbl[i].und, tbl[i].rdy);
      end
      for (int i = 0; i < 100; i++) begin
         step($sformatf("idle_%0d", i), 1'b1, 1'b0, i[0], '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Single bit 1
      step("accept_b1", 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_symbol("bit1", 0);

      // Single bit 0
      step("accept_b0", 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_symbol("bit0", 15);

      // Back-to-back bits 1,0,0
      step("b2b_accept", 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 180; j++) begin
         int sym;
         int i;
         int st;
         sym = j / 60;
         i   = j % 60;
         st  = (sym == 0) ? 0 : 15;
         step($sformatf("b2b_%0d", j), 1'b1, (j < 120), 1'b0, ADDR_W'((st + i) % 30),
              1'b1, (i == 0), 1'b1, 1'b0, (i == 59));
      end
      step("b2b_underrun", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Freeze at sample 20 of a bit-1 symbol
      vcount = 0;
      step("frz_accept", 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step($sformatf("frz_pre_%0d", i), 1'b1, 1'b0, 1'b0, ADDR_W'(i),
              1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
         vcount++;
      end
      for (int k = 0; k < 5; k++) begin
         step($sformatf("frz_hold_%0d", k), 1'b0, 1'b1, 1'b0, 5'd20,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 20; i < 60; i++) begin
         step($sformatf("frz_post_%0d", i), 1'b1, 1'b0, 1'b0, ADDR_W'(i % 30),
              1'b1, 1'b0, 1'b1, 1'b0, (i == 59));
         vcount++;
      end
      step("frz_underrun", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (vcount != 60) begin
         n_err++;
         $display("FAIL frz_total: got %0d valid samples want 60", vcount);
      end

      // Reset mid-symbol at sample 37
      step("rst_accept", 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 37; i++) begin
         step($sformatf("rst_pre_%0d", i), 1'b1, 1'b0, 1'b0, ADDR_W'(i % 30),
              1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
      end
      enable    = 1'b1;
      bit_valid = 1'b0;
      #1;
      check("rst_at37", 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      Rst_n = 1'b0;
      #1;
      check("rst_immediate", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge Clk);
      check("rst_held", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      step("rst_no_underrun", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("rst_accept_b0", 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_symbol("post_rst", 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
